// File: rtl/lock_pid_gen.sv
// PID controller for the lock chain: 4-stage pipeline, shift-scaled P/I/D terms,
// conditional-integration anti-windup, decimated block-averaged derivative and clamped output.
module lock_pid_gen #(
    parameter int DW  = 14,
    parameter int KW  = 14,
    parameter int IW  = 48,
    parameter int SW  = 5,
    parameter int DDW = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 dat_vld_i,
    input  logic signed [DW-1:0] set_sp_i,
    input  logic signed [KW-1:0] set_kp_i,
    input  logic signed [KW-1:0] set_ki_i,
    input  logic signed [KW-1:0] set_kd_i,
    input  logic [SW-1:0]        psr_i,
    input  logic [SW-1:0]        isr_i,
    input  logic [SW-1:0]        dsr_i,
    input  logic [DDW-1:0]       ddec_i,
    input  logic signed [DW-1:0] lim_hi_i,
    input  logic signed [DW-1:0] lim_lo_i,
    input  logic                 int_rst_i,
    input  logic signed [DW-1:0] int_rst_val_i,
    input  logic                 pid_freeze_i,
    input  logic                 pid_ifreeze_i,
    output logic signed [DW-1:0] dat_o,
    output logic                 dat_vld_o,
    output logic                 sat_hi_o,
    output logic                 sat_lo_o
);

    localparam int EW   = DW + 1;
    localparam int MW   = EW + KW;
    localparam int CW   = 2**DDW - 1;
    localparam int AW   = EW + CW;
    localparam int DFW  = AW + 1;
    localparam int DPW  = DFW + KW;
    localparam int IW1  = IW + 1;
    localparam int SUMW = IW + 2;

    // S1: error
    logic signed [EW-1:0] err1;
    logic                 v1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err1 <= '0;
            v1   <= 1'b0;
        end else begin
            v1   <= dat_vld_i;
            err1 <= EW'(set_sp_i) - EW'(dat_i);
        end
    end

    // S2: products and derivative block accumulation
    logic signed [MW-1:0]  p2, i2;
    logic                  v2;
    logic [DDW-1:0]        ddec_q;
    logic [CW-1:0]         cnt, cnt_last;
    logic signed [AW-1:0]  acc, acc_prev, acc_sum;
    logic signed [DFW-1:0] d_diff, d2;
    logic                  d_upd2;

    assign cnt_last = ~({CW{1'b1}} << ddec_q);
    assign acc_sum  = acc + AW'(err1);
    assign d_diff   = (DFW'(acc_sum) - DFW'(acc_prev)) >>> ddec_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p2       <= '0;
            i2       <= '0;
            v2       <= 1'b0;
            ddec_q   <= '0;
            cnt      <= '0;
            acc      <= '0;
            acc_prev <= '0;
            d2       <= '0;
            d_upd2   <= 1'b0;
        end else begin
            v2     <= v1;
            p2     <= MW'(err1) * MW'(set_kp_i);
            i2     <= MW'(err1) * MW'(set_ki_i);
            d_upd2 <= 1'b0;
            // a new block length restarts the block but keeps the previous block sum
            if (ddec_i != ddec_q) begin
                ddec_q <= ddec_i;
                cnt    <= '0;
                acc    <= '0;
            end else if (v1) begin
                if (cnt == cnt_last) begin
                    d2       <= d_diff;
                    d_upd2   <= 1'b1;
                    acc_prev <= acc_sum;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // S3: scaled P, integrator, scaled D
    logic signed [MW-1:0]  p3;
    logic signed [IW-1:0]  integ, int_sat;
    logic signed [IW1-1:0] int_add;
    logic signed [DPW-1:0] d_prod, dterm3;
    logic                  aw_block;
    logic                  v3;

    assign int_add  = IW1'(integ) + IW1'(i2);
    assign aw_block = (sat_hi_o && !i2[MW-1] && (i2 != '0)) || (sat_lo_o && i2[MW-1]);
    assign d_prod   = (DPW'(d2) * DPW'(set_kd_i)) >>> dsr_i;

    always_comb begin
        int_sat = int_add[IW-1:0];
        if (int_add[IW] != int_add[IW-1])
            int_sat = int_add[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p3     <= '0;
            integ  <= '0;
            dterm3 <= '0;
            v3     <= 1'b0;
        end else begin
            v3 <= v2;
            p3 <= p2 >>> psr_i;
            // load is honoured on any cycle and overrides freeze and anti-windup
            if (int_rst_i)
                integ <= IW'(int_rst_val_i) <<< isr_i;
            else if (v2 && !pid_ifreeze_i && !aw_block)
                integ <= int_sat;
            if (d_upd2)
                dterm3 <= d_prod;
        end
    end

    // S4: sum and clamp
    logic signed [IW-1:0]   iterm;
    logic signed [SUMW-1:0] sum, lim_hi_x, lim_lo_x;

    assign iterm    = integ >>> isr_i;
    assign sum      = SUMW'(p3) + SUMW'(iterm) + SUMW'(dterm3);
    assign lim_hi_x = SUMW'(lim_hi_i);
    assign lim_lo_x = SUMW'(lim_lo_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dat_o     <= '0;
            dat_vld_o <= 1'b0;
            sat_hi_o  <= 1'b0;
            sat_lo_o  <= 1'b0;
        end else begin
            dat_vld_o <= v3;
            if (v3 && !pid_freeze_i) begin
                if (lim_lo_i > lim_hi_i) begin
                    dat_o    <= '0;
                    sat_hi_o <= 1'b1;
                    sat_lo_o <= 1'b1;
                end else if (sum > lim_hi_x) begin
                    dat_o    <= lim_hi_i;
                    sat_hi_o <= 1'b1;
                    sat_lo_o <= 1'b0;
                end else if (sum < lim_lo_x) begin
                    dat_o    <= lim_lo_i;
                    sat_hi_o <= 1'b0;
                    sat_lo_o <= 1'b1;
                end else begin
                    dat_o    <= sum[DW-1:0];
                    sat_hi_o <= 1'b0;
                    sat_lo_o <= 1'b0;
                end
            end
        end
    end

endmodule
